// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper command sequencer.
//   state_e     : sequencer FSM states (idle / running a move)
//   PhaseTable  : gray-coded phase drive indexed by the 2-bit phase index
//   DirFwd/Rev  : encoding of the command direction bit
//   next_index  : one gray step forward or backward with 2-bit wrap
package stepper_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam logic DirFwd = 1'b1;
  localparam logic DirRev = 1'b0;

  // Element [i] is the drive pattern for phase index i: 00, 01, 11, 10.
  localparam logic [3:0][1:0] PhaseTable = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] next_index(input logic [1:0] idx, input logic dir);
    logic [1:0] nxt;
    if (dir == DirFwd) nxt = idx + 2'd1;
    else               nxt = idx - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period prescaler.
// Counts 0..CLK_DIV-1 while run is high and wraps; the count is held at zero
// whenever run is low so every move starts a full period from acceptance.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   run   : enable counting (sequencer is in RUN)
//   tick  : one-cycle pulse while the count sits at its terminal value
module step_prescaler #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run)                 cnt_d = '0;
    else if (cnt_q == CntLast) cnt_d = '0;
    else                      cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == CntLast);

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// Command-driven sequencer for the 2-bit gray-coded phase drive.
// Accepts a move (direction + step count) on a valid/ready handshake, paces
// steps with step_prescaler and advances the phase one gray step per period.
// Optional build macro: POS_TRACK_EN adds a signed position counter
// (output position) and a synchronous clear input (pos_clear).
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake, ready only while idle
//   cmd_dir, cmd_steps  : 1 = forward / 0 = reverse, number of steps
//   abort               : stop the current move
//   phase               : gray-coded drive phase
//   busy                : move in progress
//   done, aborted       : one-cycle completion / abort pulses
//   steps_left          : remaining steps of the current move
module stepper_cmd_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned POS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left
`ifdef POS_TRACK_EN
  ,
  input  logic                    pos_clear,
  output logic signed [POS_W-1:0] position
`endif
);

  // Elaboration-time sanity on the configuration.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if (POS_W < 2) begin : g_bad_pos_w
    $error("POS_W must be at least 2");
  end

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [1:0]        phase_q;
  logic              dir_q;
  logic [STEP_W-1:0] steps_left_q;
  logic              done_q;
  logic              aborted_q;

  logic       run;
  logic       tick;
  logic [1:0] idx_next;
  logic       step_fire;

  assign run       = (state_q == StRun);
  assign idx_next  = next_index(idx_q, dir_q);
  // Abort wins over a coincident terminal count, so no step is taken.
  assign step_fire = run && tick && !abort;

  step_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      phase_q      <= 2'b00;
      dir_q        <= DirFwd;
      steps_left_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort is ignored here; an offered command is still taken.
          if (cmd_valid) begin
            dir_q        <= cmd_dir;
            steps_left_q <= cmd_steps;
            if (cmd_steps == '0) done_q  <= 1'b1;
            else                 state_q <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            state_q   <= StIdle;
            aborted_q <= 1'b1;
          end else if (tick) begin
            idx_q        <= idx_next;
            phase_q      <= PhaseTable[idx_next];
            // steps_left is at least 1 throughout RUN, so this cannot wrap.
            steps_left_q <= steps_left_q - STEP_W'(1);
            if (steps_left_q == STEP_W'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = run;
  assign phase      = phase_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_left_q;

`ifdef POS_TRACK_EN
  logic signed [POS_W-1:0] pos_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= '0;
    end else if (pos_clear) begin
      pos_q <= '0;
    end else if (step_fire) begin
      if (dir_q == DirFwd) pos_q <= pos_q + POS_W'(1);
      else                 pos_q <= pos_q - POS_W'(1);
    end
  end

  assign position = pos_q;
`endif

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Scoreboard bench for stepper_cmd_sequencer with CLK_DIV = 4.
// Stimulus pushes hand-computed expected events (step, done, abort) with the
// cycle they must appear on; a negedge monitor pops and compares them.
module tb_stepper_cmd_sequencer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned STEP_W  = 8;
  localparam int unsigned POS_W   = 16;

  localparam int EvStep  = 0;
  localparam int EvDone  = 1;
  localparam int EvAbort = 2;

  typedef struct {
    int          kind;
    logic [1:0]  ph;
    logic [7:0]  sl;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              abort = 1'b0;
  logic [1:0]        phase;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_left;
  logic              pos_clear = 1'b0;
`ifdef POS_TRACK_EN
  logic signed [POS_W-1:0] position;
`endif

  stepper_cmd_sequencer #(
    .CLK_DIV (CLK_DIV),
    .STEP_W  (STEP_W),
    .POS_W   (POS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .abort      (abort),
    .phase      (phase),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_left (steps_left)
`ifdef POS_TRACK_EN
    ,
    .pos_clear  (pos_clear),
    .position   (position)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [1:0] ph, input logic [7:0] sl);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.ph   = ph;
    e.sl   = sl;
    q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d phase %b steps_left %0d at cyc %0d, expected none",
               kind, phase, steps_left, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.ph !== phase || e.sl !== steps_left || e.cyc != cyc) begin
      errors++;
      $display("FAIL event: got kind %0d phase %b steps_left %0d cyc %0d, expected kind %0d phase %b steps_left %0d cyc %0d",
               kind, phase, steps_left, cyc, e.kind, e.ph, e.sl, e.cyc);
    end
  endtask

  // Monitor: every phase change, done pulse or aborted pulse is an event.
  logic [1:0] prev_ph = 2'b00;
  always @(negedge clk) begin
    if (!reset) begin
      prev_ph = 2'b00;
    end else begin
      if (phase !== prev_ph) check_event(EvStep);
      if (done)              check_event(EvDone);
      if (aborted)           check_event(EvAbort);
      prev_ph = phase;
    end
  end

  // Issue one command; returns the index of the acceptance edge.
  task automatic send(input logic dir, input int steps, output int acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = STEP_W'(steps);
    @(posedge clk);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain, then a quiet margin.
  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, 32'(q.size()), 32'd0);
    q.delete();
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;

    // Reset state.
    #1;
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_aborted", 32'(aborted), 32'h0);
    chk("rst_steps_left", 32'(steps_left), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Forward 3: 01, 11, 10.
    send(1'b1, 3, a);
    push(EvStep, a + 4, 2'b01, 8'd2);
    push(EvStep, a + 8, 2'b11, 8'd1);
    push(EvStep, a + 12, 2'b10, 8'd0);
    push(EvDone, a + 12, 2'b10, 8'd0);
    chk("fwd3_busy", 32'(busy), 32'h1);
    chk("fwd3_ready", 32'(cmd_ready), 32'h0);
    chk("fwd3_steps_left", 32'(steps_left), 32'd3);
    wait_empty("fwd3", 40);
    chk("fwd3_idle_busy", 32'(busy), 32'h0);
`ifdef POS_TRACK_EN
    chk("fwd3_position", 32'(position), 32'd3);
`endif

    // Reverse 5 from 10: 11, 01, 00, 10, 11.
    send(1'b0, 5, a);
    push(EvStep, a + 4, 2'b11, 8'd4);
    push(EvStep, a + 8, 2'b01, 8'd3);
    push(EvStep, a + 12, 2'b00, 8'd2);
    push(EvStep, a + 16, 2'b10, 8'd1);
    push(EvStep, a + 20, 2'b11, 8'd0);
    push(EvDone, a + 20, 2'b11, 8'd0);
    wait_empty("rev5", 60);
`ifdef POS_TRACK_EN
    chk("rev5_position", 32'(position), 32'hFFFF_FFFE);
`endif

    // Zero-step command: done only, never busy.
    send(1'b1, 0, a);
    push(EvDone, a, 2'b11, 8'd0);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_ready", 32'(cmd_ready), 32'h1);
    wait_empty("zero", 10);
    chk("zero_phase", 32'(phase), 32'(2'b11));

    // Forward 10 from 11, abort coincident with the third terminal count.
    send(1'b1, 10, a);
    push(EvStep, a + 4, 2'b10, 8'd9);
    push(EvStep, a + 8, 2'b00, 8'd8);
    push(EvAbort, a + 12, 2'b00, 8'd8);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_steps_left", 32'(steps_left), 32'd8);
    wait_empty("abort", 20);
    chk("abort_phase_hold", 32'(phase), 32'h0);

    // Reset in the middle of a forward 6 move.
    send(1'b1, 6, a);
    push(EvStep, a + 4, 2'b01, 8'd5);
    push(EvStep, a + 8, 2'b11, 8'd4);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_steps_left", 32'(steps_left), 32'd4);
    chk("mid_queue", 32'(q.size()), 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst_phase", 32'(phase), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_steps_left", 32'(steps_left), 32'h0);
    chk("mrst_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
`ifdef POS_TRACK_EN
    chk("mrst_position", 32'(position), 32'd0);
`endif

    // Fresh move after reset; pos_clear lands on the second step.
    send(1'b1, 2, a);
    push(EvStep, a + 4, 2'b01, 8'd1);
    push(EvStep, a + 8, 2'b11, 8'd0);
    push(EvDone, a + 8, 2'b11, 8'd0);
    repeat (7) @(posedge clk);
    #1 pos_clear = 1'b1;
    @(posedge clk);
    #1 pos_clear = 1'b0;
    wait_empty("post_rst", 30);
`ifdef POS_TRACK_EN
    chk("clear_position", 32'(position), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_cmd_sequencer.md
Name: stepper_cmd_sequencer

Overview:
Command-driven sequencer for the machine's 2-bit gray-coded phase drive (the stepper/LED phase pair).
- Accepts a move command: direction plus step count, via valid/ready handshake.
- Paces steps with an internal prescaler and advances the phase one gray step per period.
- Reports busy, done and aborted.
- Sits between the front-panel/control logic and the phase outputs; replaces free-running switch-driven stepping.

Parameters:
CLK_DIV, 50000000, clk cycles per step period (≥2)
STEP_W, 8, width of step-count field and remaining-step counter
POS_W, 16, width of position counter (used only with optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept; high only in IDLE
cmd_dir  input  1  1 = forward, 0 = reverse
cmd_steps  input  STEP_W  number of steps to take
abort  input  1  stop current move
phase  output  2  gray-coded drive phase
busy  output  1  high in RUN
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on abort
steps_left  output  STEP_W  remaining steps of current move

Behaviour:
- Reset (reset=0, async): state=IDLE, phase=00, phase index=0, prescaler=0, steps_left=0, busy=0, done=0, aborted=0, cmd_ready=1. Reset mid-move discards the move with no done/aborted pulse.
- Phase map from index 0..3: 00, 01, 11, 10.
  - Forward: index+1 mod 4 (00→01→11→10→00).
  - Reverse: index−1 mod 4 (00→10→11→01→00).
  - Phase holds between commands; never re-homed except by reset.
- States: IDLE, RUN.
- IDLE, cmd_valid=1 (ready=1): latch dir and steps.
  - If cmd_steps=0: stay IDLE, done=1 next cycle, phase unchanged.
  - Else: → RUN, steps_left=cmd_steps, prescaler=0.
- RUN:
  - Prescaler counts 0..CLK_DIV−1 and wraps.
  - At terminal count: phase advances one step in the latched dir; steps_left decrements.
  - First step lands CLK_DIV cycles after the acceptance edge; later steps every CLK_DIV cycles.
  - On the step that makes steps_left 0: → IDLE the same edge; done=1 for the following cycle; cmd_ready=1 from that cycle.
- Abort in RUN: → IDLE next edge; phase and steps_left hold; aborted=1 one cycle; no done.
- Abort coincident with terminal count: abort wins; no step taken.
- Abort in IDLE: ignored. An offered command is still accepted the same cycle.
- cmd_valid while RUN: ignored (ready=0). Requester must hold it; no queueing.
- Arithmetic: steps_left unsigned, never underflows. Index arithmetic is 2-bit wrap.
- done and aborted are registered and mutually exclusive.

Optional Feature:
Macro POS_TRACK_EN.
- Defined: adds output position (POS_W, signed), reset 0. Incremented on each forward step, decremented on each reverse step, two's-complement wrap. Adds input pos_clear: synchronous zero; if coincident with a step, clear wins.
- Undefined: neither port exists; no position logic.

Decomposition:
- Package stepper_pkg: state enum (IDLE, RUN); 4-entry gray phase constant table; DIR_FWD/DIR_REV constants.
- One natural sub-module: step_prescaler.
  - Parameter CLK_DIV; inputs clk, reset, run.
  - Emits a one-cycle tick at terminal count.
  - Count clears when run=0.

Test Plan:
- CLK_DIV=4. Reset release, then cmd fwd steps=3 → phase 01 @ +4 cycles, 11 @ +8, 10 @ +12; done pulses cycle after +12; busy high +1..+12.
- Continue from phase 10, cmd rev steps=5 → 11, 01, 00, 10, 11; steps_left counts 5→0; single done pulse.
- cmd steps=0 → no phase change; done one cycle later; busy never asserts.
- cmd fwd steps=10, abort at cycle where prescaler=3 after 2 steps → no third step; aborted=1 once; steps_left=8; phase holds; cmd_ready returns 1.
- Reset low mid-move (steps_left=4) → phase=00, busy=0, steps_left=0 immediately, no done/aborted; new command after release runs normally.
- POS_TRACK_EN: fwd 3 then rev 5 → position 3 then −2; pos_clear coincident with a step → position 0.
